// File: rtl/mips_pkg.sv
// Shared types and encodings for the MIPS hazard/forwarding logic.
// Select codes for the D and E operand muxes and the Tnew/Tuse type.
package mips_pkg;

    typedef logic [1:0] tnew_t;

    localparam logic [1:0] FWD_D_RF = 2'd0;
    localparam logic [1:0] FWD_D_E  = 2'd1;
    localparam logic [1:0] FWD_D_M  = 2'd2;

    localparam logic [1:0] FWD_E_HOLD = 2'd0;
    localparam logic [1:0] FWD_E_M    = 2'd1;
    localparam logic [1:0] FWD_E_W    = 2'd2;

    localparam tnew_t TUSE_NONE = 2'd3;

    function automatic tnew_t tnew_dec(input tnew_t t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy counter: loads on an E-stage start,
// then counts down to zero; busy while non-zero.
module md_busy_cnt #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= is_div ? DIV_LD : MULT_LD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding control for the 5-stage pipeline.
// Tracks register numbers/Tnew through E, M and W shadows.
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic       e_md_start,
    input  logic       e_md_div,
    output logic       stall,
    output logic       f_we,
    output logic       d_we,
    output logic       e_clr,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       md_busy
);

    logic [4:0] e_rs, e_rt, e_wa;
    tnew_t      e_tnew;
    logic [4:0] m_wa;
    tnew_t      m_tnew;
    logic [4:0] w_wa;

    logic hz_rs, hz_rt, hz_md;

    function automatic logic data_hz(
        input logic [4:0] r,
        input tnew_t      tuse,
        input logic [4:0] ewa,
        input tnew_t      et,
        input logic [4:0] mwa,
        input tnew_t      mt
    );
        if (r == 5'd0 || tuse == TUSE_NONE) return 1'b0;
        return (r == ewa && et > tuse) || (r == mwa && mt > tuse);
    endfunction

    function automatic logic [1:0] sel_d(
        input logic [4:0] r,
        input logic       hz,
        input logic [4:0] ewa,
        input tnew_t      et,
        input logic [4:0] mwa,
        input tnew_t      mt
    );
        if (hz || r == 5'd0) return FWD_D_RF;
        if (r == ewa && et == 2'd0) return FWD_D_E;
        if (r == mwa && mt == 2'd0) return FWD_D_M;
        return FWD_D_RF;
    endfunction

    function automatic logic [1:0] sel_e(
        input logic [4:0] r,
        input logic [4:0] mwa,
        input tnew_t      mt,
        input logic [4:0] wwa
    );
        if (r == 5'd0) return FWD_E_HOLD;
        if (r == mwa && mt == 2'd0) return FWD_E_M;
        if (r == wwa) return FWD_E_W;
        return FWD_E_HOLD;
    endfunction

    // A stalled D instruction leaves a bubble in E behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs   <= '0;
            e_rt   <= '0;
            e_wa   <= '0;
            e_tnew <= '0;
            m_wa   <= '0;
            m_tnew <= '0;
            w_wa   <= '0;
        end else begin
            if (stall) begin
                e_rs   <= '0;
                e_rt   <= '0;
                e_wa   <= '0;
                e_tnew <= '0;
            end else begin
                e_rs   <= d_rs;
                e_rt   <= d_rt;
                e_wa   <= d_wa;
                e_tnew <= d_tnew;
            end
            m_wa   <= e_wa;
            m_tnew <= tnew_dec(e_tnew);
            w_wa   <= m_wa;
        end
    end

    md_busy_cnt #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_cnt (
        .clk   (clk),
        .reset (reset),
        .start (e_md_start),
        .is_div(e_md_div),
        .busy  (md_busy)
    );

    always_comb begin
        hz_rs = data_hz(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
        hz_rt = data_hz(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
        hz_md = d_md_use && (md_busy || e_md_start);
    end

    assign stall = hz_rs | hz_rt | hz_md;
    assign f_we  = ~stall;
    assign d_we  = ~stall;
    assign e_clr = stall;

    assign fwd_d_rs = sel_d(d_rs, hz_rs, e_wa, e_tnew, m_wa, m_tnew);
    assign fwd_d_rt = sel_d(d_rt, hz_rt, e_wa, e_tnew, m_wa, m_tnew);
    assign fwd_e_rs = sel_e(e_rs, m_wa, m_tnew, w_wa);
    assign fwd_e_rt = sel_e(e_rt, m_wa, m_tnew, w_wa);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Each task drives one scenario and checks hand-derived values.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_use, e_md_start, e_md_div;
    logic       stall, f_we, d_we, e_clr, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_wa      (d_wa),
        .d_tnew    (d_tnew),
        .d_md_use  (d_md_use),
        .e_md_start(e_md_start),
        .e_md_div  (e_md_div),
        .stall     (stall),
        .f_we      (f_we),
        .d_we      (d_we),
        .e_clr     (e_clr),
        .fwd_d_rs  (fwd_d_rs),
        .fwd_d_rt  (fwd_d_rt),
        .fwd_e_rs  (fwd_e_rs),
        .fwd_e_rt  (fwd_e_rt),
        .md_busy   (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        d_rs = 0; d_rt = 0; d_wa = 0; d_tnew = 0;
        d_tuse_rs = 3; d_tuse_rt = 3;
        d_md_use = 0; e_md_start = 0; e_md_div = 0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({stall, e_clr, md_busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: stall/e_clr/busy=%b exp=000",
                     {stall, e_clr, md_busy});
        end
        checks++;
        if ({f_we, d_we} !== 2'b11) begin
            errors++;
            $display("FAIL reset_we: f_we/d_we=%b exp=11", {f_we, d_we});
        end
        checks++;
        if ({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt} !== 8'h00) begin
            errors++;
            $display("FAIL reset_fwd: fwd=%h exp=00",
                     {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt});
        end
    endtask

    task automatic test_load_use;
        do_reset();
        d_wa = 1; d_tnew = 2;
        tick();
        idle();
        d_rs = 1; d_tuse_rs = 1; d_rt = 3; d_tuse_rt = 1; d_wa = 2; d_tnew = 1;
        #1;
        checks++;
        if ({stall, e_clr, f_we} !== 3'b110) begin
            errors++;
            $display("FAIL lu_stall1: stall/e_clr/f_we=%b exp=110",
                     {stall, e_clr, f_we});
        end
        tick();
        checks++;
        if ({stall, fwd_d_rs} !== 3'b000) begin
            errors++;
            $display("FAIL lu_stall2: stall/fwd_d_rs=%b exp=000",
                     {stall, fwd_d_rs});
        end
        tick();
        idle();
        #1;
        checks++;
        if (fwd_e_rs !== 2'd2) begin
            errors++;
            $display("FAIL lu_fwd_e_rs: got=%0d exp=2", fwd_e_rs);
        end
        checks++;
        if (fwd_e_rt !== 2'd0) begin
            errors++;
            $display("FAIL lu_fwd_e_rt: got=%0d exp=0", fwd_e_rt);
        end
    endtask

    task automatic test_load_branch;
        int n = 0;
        do_reset();
        d_wa = 1; d_tnew = 2;
        tick();
        idle();
        d_rs = 1; d_tuse_rs = 0; d_tuse_rt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (!stall) break;
            n++;
            tick();
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL lb_stall_cycles: got=%0d exp=2", n);
        end
        checks++;
        if (fwd_d_rs !== 2'd0) begin
            errors++;
            $display("FAIL lb_fwd_d_rs: got=%0d exp=0", fwd_d_rs);
        end
    endtask

    task automatic test_alu_chain;
        do_reset();
        d_wa = 4; d_tnew = 1;
        tick();
        idle();
        d_rs = 4; d_rt = 4; d_tuse_rs = 1; d_tuse_rt = 1; d_wa = 5; d_tnew = 1;
        #1;
        checks++;
        if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0) begin
            errors++;
            $display("FAIL alu_d: stall/fwd_d=%b exp=00000",
                     {stall, fwd_d_rs, fwd_d_rt});
        end
        tick();
        idle();
        #1;
        checks++;
        if ({fwd_e_rs, fwd_e_rt} !== 4'b0101) begin
            errors++;
            $display("FAIL alu_fwd_e: rs=%0d rt=%0d exp=1/1",
                     fwd_e_rs, fwd_e_rt);
        end
    endtask

    task automatic test_d_forward;
        do_reset();
        d_wa = 31; d_tnew = 0;
        tick();
        idle();
        d_rs = 31; d_tuse_rs = 0;
        #1;
        checks++;
        if ({stall, fwd_d_rs} !== 3'b001) begin
            errors++;
            $display("FAIL dfwd_e: stall/fwd_d_rs=%b exp=001",
                     {stall, fwd_d_rs});
        end
        idle();
        d_wa = 6; d_tnew = 1;
        tick();
        idle();
        tick();
        d_rt = 6; d_tuse_rt = 0;
        #1;
        checks++;
        if ({stall, fwd_d_rt} !== 3'b010) begin
            errors++;
            $display("FAIL dfwd_m: stall/fwd_d_rt=%b exp=010",
                     {stall, fwd_d_rt});
        end
        idle();
        d_wa = 8; d_tnew = 2;
        tick();
        idle();
        d_rs = 8; d_tuse_rs = 3;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL tuse_none: stall=%b exp=0", stall);
        end
    endtask

    task automatic md_run(input logic is_div, input int exp_stall,
                          input int exp_busy);
        int ns = 0;
        int nb = 0;
        do_reset();
        d_md_use = 1; e_md_start = 1; e_md_div = is_div;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (stall) ns++;
            if (md_busy) nb++;
            tick();
            e_md_start = 0;
        end
        checks++;
        if (ns != exp_stall) begin
            errors++;
            $display("FAIL md_stall div=%b: got=%0d exp=%0d",
                     is_div, ns, exp_stall);
        end
        checks++;
        if (nb != exp_busy) begin
            errors++;
            $display("FAIL md_busy div=%b: got=%0d exp=%0d",
                     is_div, nb, exp_busy);
        end
    endtask

    task automatic test_md;
        md_run(1'b0, 6, 5);
        md_run(1'b1, 11, 10);
    endtask

    task automatic test_reset_mid_div;
        do_reset();
        d_wa = 7; d_tnew = 2; e_md_start = 1; e_md_div = 1;
        tick();
        e_md_start = 0;
        tick(); tick(); tick();
        checks++;
        if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_busy_pre: md_busy=%b exp=1", md_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        d_rs = 7; d_tuse_rs = 0; d_md_use = 1;
        #1;
        checks++;
        if ({md_busy, stall} !== 2'b00) begin
            errors++;
            $display("FAIL rd_after: busy/stall=%b exp=00", {md_busy, stall});
        end
        checks++;
        if ({fwd_d_rs, fwd_e_rs, fwd_e_rt} !== 6'b0) begin
            errors++;
            $display("FAIL rd_fwd: fwd=%b exp=000000",
                     {fwd_d_rs, fwd_e_rs, fwd_e_rt});
        end
    endtask

    task automatic test_zero_reg;
        do_reset();
        d_wa = 0; d_tnew = 2;
        tick();
        idle();
        d_tuse_rs = 0; d_tuse_rt = 0;
        #1;
        checks++;
        if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0) begin
            errors++;
            $display("FAIL zero_d: stall/fwd_d=%b exp=00000",
                     {stall, fwd_d_rs, fwd_d_rt});
        end
        tick();
        checks++;
        if ({stall, fwd_e_rs, fwd_e_rt} !== 5'b0) begin
            errors++;
            $display("FAIL zero_e: stall/fwd_e=%b exp=00000",
                     {stall, fwd_e_rs, fwd_e_rt});
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_chain();
        test_d_forward();
        test_md();
        test_reset_mid_div();
        test_zero_reg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps a shadow pipeline of destination/source register numbers and Tnew values that follows the D/E, E/M and M/W registers.
- Drives stall and bubble controls for the F/D and D/E pipeline registers.
- Generates forwarding mux selects for the D-stage and E-stage operand muxes.
- Sequences the multi-cycle multiply/divide unit with a busy counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, busy counter width; must hold DIV_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- d_rs, d_rt  in  5 each  D-stage source register numbers
- d_tuse_rs, d_tuse_rt  in  2 each  cycles until operand is needed (0 = D stage, 1 = E, 2 = M; 3 = unused)
- d_wa  in  5  D-stage destination register (0 = none)
- d_tnew  in  2  Tnew of the D instruction once it reaches E (lw 2, ALU 1, jal 0)
- d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- e_md_start  in  1  mult/div currently in E (start pulse to the MDU)
- e_md_div  in  1  qualifies e_md_start: 1 = div, 0 = mult
- stall  out  1  hazard stall
- f_we, d_we  out  1 each  PC and F/D register write enables (= ~stall)
- e_clr  out  1  D/E register flush, inserts a bubble (= stall)
- fwd_d_rs, fwd_d_rt  out  2 each  D-stage operand select: 0 = register file, 1 = E result (PC+8), 2 = M ALU result
- fwd_e_rs, fwd_e_rt  out  2 each  E-stage operand select: 0 = D/E latched value, 1 = M ALU result, 2 = W write data
- md_busy  out  1  MDU busy counter non-zero

Behaviour:
- Reset is synchronous, clk posedge. All shadow registers, Tnew values and the busy counter clear to 0. With the shadows cleared, all outputs are 0 except f_we = d_we = 1.
- Shadow E stage (e_rs, e_rt, e_wa, e_tnew) per edge:
  - stall = 1: clears to 0 (bubble).
  - stall = 0: loads d_rs, d_rt, d_wa, d_tnew.
- Shadow M stage (m_rt, m_wa, m_tnew): loads E shadow every edge, with m_tnew = max(e_tnew - 1, 0).
- Shadow W stage (w_wa): loads m_wa every edge. W Tnew is always 0.
- Register 0 never matches in any hazard or forward comparison.
- Data stall (combinational): a source X in {rs, rt} stalls when either condition holds:
  - d_X == e_wa and e_tnew > d_tuse_X
  - d_X == m_wa and m_tnew > d_tuse_X
  - d_tuse_X = 3 never stalls.
  - No stall is generated against W; the register file performs write-through.
- MDU stall: d_md_use and (md_busy or e_md_start).
- stall is the OR of both data conditions and the MDU condition.
- D forward selects (only when no stall applies to that source), first match wins:
  - 1 if d_X == e_wa and e_tnew == 0
  - 2 if d_X == m_wa and m_tnew == 0
  - otherwise 0
- E forward selects: M has priority over W.
  - 1 if e_X == m_wa and m_tnew == 0
  - 2 if e_X == w_wa
  - otherwise 0
- Busy counter:
  - On an edge with e_md_start: loads DIV_CYCLES if e_md_div, else MULT_CYCLES. Load has priority over decrement.
  - Otherwise decrements while non-zero.
  - md_busy = (count != 0).
- Reset in the middle of a div forces count to 0, so md_busy drops on the next cycle.
- A stall and an e_md_start in the same cycle are legal; the counter still loads.

Decomposition:
- Shared package mips_pkg holds:
  - FWD_RF/FWD_E/FWD_M and FWD_HOLD/FWD_M/FWD_W select encodings
  - TUSE_NONE = 3
  - the 2-bit Tnew type
- One sub-module, md_busy_cnt (counter, load/decrement), is natural.
- Shadow-pipeline and compare logic stay in the top module.

Test Plan:
- lw $1 then add $2,$1,$3 (tuse_rs = 1) -> stall = 1 for exactly 1 cycle, e_clr = 1 for that cycle; next cycle the add is in E and fwd_e_rs = 2.
- lw $1 then beq $1,$0 (tuse 0) -> 2 stall cycles; after that fwd_d_rs = 0 (register-file write-through).
- addu $4 then subu $5,$4,$4 -> no stall; fwd_e_rs = fwd_e_rt = 1 while the subu is in E.
- mult in E with mfhi in D -> stall for 1 + MULT_CYCLES = 6 cycles; md_busy high for 5; with e_md_div = 1 -> 11 cycles.
- div started, reset asserted 3 cycles later -> md_busy = 0 and stall = 0 the cycle after reset; shadows are zero.
- Instruction with d_wa = 0 and lw-class d_tnew = 2, followed by a user of $0 -> no stall, all forward selects 0.
